// File: rtl/dpcm_channel_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : dpcm_channel_scheduler_if
// Purpose  : Bundles the request side (per-channel valid/data/ready) and the
//            residual output side (valid/ready with data and channel tag) of
//            the DPCM channel scheduler.
// Signals  : req_valid [N_CH]   channel i has a sample pending
//            req_data  [8*N_CH] unsigned sample of channel i at [8i+7:8i]
//            req_ready [N_CH]   one-cycle accept pulse for channel i
//            out_valid          residual available
//            out_data  [8]      signed residual
//            out_ch    [3]      channel tag of out_data
//            out_ready          downstream accepts out_data
// Modports : master = sample sources / packer side, slave = scheduler
// Revision : 1.0 - initial release
// ============================================================================
interface dpcm_channel_scheduler_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0]   req_valid;
  logic [8*N_CH-1:0] req_data;
  logic [N_CH-1:0]   req_ready;
  logic              out_valid;
  logic [7:0]        out_data;
  logic [2:0]        out_ch;
  logic              out_ready;

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_ch
  );

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_ch
  );
endinterface
`default_nettype wire

// File: rtl/dpcm_channel_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : dpcm_channel_scheduler
// Purpose  : Time-shares one DPCM subtract/saturate/reconstruct datapath
//            between N_CH sample channels. A round-robin arbiter picks the
//            next requesting channel, each channel owns a private predictor,
//            and every residual leaves tagged with its channel index.
// Ports    : clk        system clock, rising edge
//            reset      synchronous, active-high
//            pred_clear [N_CH] level clear of predictor i (only when
//                       DPCM_PRED_CLEAR_EN is defined)
//            bus        dpcm_channel_scheduler_if.slave (request/response)
//            state_out  [2] FSM state: IDLE=0, DIFF=1, SAT=2, OUT=3
// Options  : DPCM_PRED_CLEAR_EN - adds the pred_clear input
// Revision : 1.0 - initial release
// ============================================================================
module dpcm_channel_scheduler #(
  parameter int N_CH    = 4,
  parameter int SAT_LIM = 63
) (
  input  wire logic                    clk,
  input  wire logic                    reset,
`ifdef DPCM_PRED_CLEAR_EN
  input  wire logic [N_CH-1:0]         pred_clear,
`endif
  dpcm_channel_scheduler_if.slave      bus,
  output logic      [1:0]              state_out
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic signed [8:0] C_POS_LIM = 9'(SAT_LIM);
  localparam logic signed [8:0] C_NEG_LIM = -9'(SAT_LIM);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIFF = 2'd1,
    SAT  = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t             r_state;
  logic [2:0]         r_last_grant;
  logic [2:0]         r_ch;
  logic [7:0]         r_sample;
  logic signed [8:0]  r_diff;
  logic [7:0]         r_pred [N_CH];
  logic               r_out_valid;
  logic [7:0]         r_out_data;
  logic [2:0]         r_out_ch;

  logic               w_found;
  logic [2:0]         w_grant;
  logic [3:0]         w_idx;
  logic signed [7:0]  w_q;

  // Round-robin search starting one past the last granted channel.
  // last_grant + k never exceeds 15 and wraps at most once, so a single
  // conditional subtract implements the modulo.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int k = 1; k <= N_CH; k++) begin
      w_idx = {1'b0, r_last_grant} + 4'(k);
      if (w_idx >= 4'(N_CH)) begin
        w_idx = w_idx - 4'(N_CH);
      end
      if (!w_found && bus.req_valid[w_idx[CH_W-1:0]]) begin
        w_found = 1'b1;
        w_grant = w_idx[2:0];
      end
    end
  end

  // Accept pulse is asserted in the grant cycle itself so the source sees
  // ready alongside the edge that captures its sample.
  always_comb begin
    bus.req_ready = '0;
    if (!reset && r_state == IDLE && w_found) begin
      bus.req_ready[w_grant[CH_W-1:0]] = 1'b1;
    end
  end

  always_comb begin
    if (r_diff > C_POS_LIM) begin
      w_q = C_POS_LIM[7:0];
    end else if (r_diff < C_NEG_LIM) begin
      w_q = C_NEG_LIM[7:0];
    end else begin
      w_q = r_diff[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_grant <= 3'(N_CH - 1);
      r_ch         <= '0;
      r_sample     <= '0;
      r_diff       <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_ch     <= '0;
      for (int i = 0; i < N_CH; i++) begin
        r_pred[i] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_sample     <= bus.req_data[8*w_grant +: 8];
            r_ch         <= w_grant;
            r_last_grant <= w_grant;
            r_state      <= DIFF;
          end
        end
        DIFF: begin
          r_diff  <= $signed({1'b0, r_sample}) - $signed({1'b0, r_pred[r_ch[CH_W-1:0]]});
          r_state <= SAT;
        end
        SAT: begin
          // Clipped step keeps the new predictor between the old one and
          // the sample, so a modulo-256 add cannot wrap.
          r_pred[r_ch[CH_W-1:0]] <= r_pred[r_ch[CH_W-1:0]] + $unsigned(w_q);
          r_out_data  <= $unsigned(w_q);
          r_out_ch    <= r_ch;
          r_out_valid <= 1'b1;
          r_state     <= OUT;
        end
        OUT: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
`ifdef DPCM_PRED_CLEAR_EN
      // Placed after the FSM so a clear overrides a same-cycle SAT write.
      for (int i = 0; i < N_CH; i++) begin
        if (pred_clear[i]) begin
          r_pred[i] <= '0;
        end
      end
`endif
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_ch    = r_out_ch;
  assign state_out     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_dpcm_channel_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_dpcm_channel_scheduler
// Purpose  : Directed, table-driven bench for dpcm_channel_scheduler with
//            hand-written sequences for arbitration, back-pressure, reset
//            abort and (when DPCM_PRED_CLEAR_EN is defined) predictor clear.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dpcm_channel_scheduler;

  localparam int N_CH = 4;

  logic       clk;
  logic       reset;
  logic [1:0] state_out;
`ifdef DPCM_PRED_CLEAR_EN
  logic [N_CH-1:0] pred_clear;
`endif

  dpcm_channel_scheduler_if #(.N_CH(N_CH)) bus ();

  dpcm_channel_scheduler #(.N_CH(N_CH), .SAT_LIM(63)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef DPCM_PRED_CLEAR_EN
    .pred_clear(pred_clear),
`endif
    .bus       (bus),
    .state_out (state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    int         ch;
    logic [7:0] data;
    logic [7:0] exp_d;
  } vec_t;

  vec_t vecs [12];
  int   gnt_ch  [4];
  int   gnt_cyc [4];
  logic [7:0] outs [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Issue one sample, check grant, 3-cycle latency, residual, tag and return
  // to IDLE. Called at posedge+1 with out_ready high.
  task automatic do_txn(input int ch, input logic [7:0] data, input logic [7:0] exp_d, input string name);
    int n;
    bus.req_valid = '0;
    bus.req_valid[ch] = 1'b1;
    bus.req_data[8*ch +: 8] = data;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready[ch] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({name, "/grant"}, 32'(bus.req_ready), 32'(1 << ch));
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    bus.req_data[8*ch +: 8] = ~data;
    n = 1;
    @(negedge clk);
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({name, "/latency"}, 32'(n), 32'd3);
    chk({name, "/data"}, 32'(bus.out_data), 32'(exp_d));
    chk({name, "/ch"}, 32'(bus.out_ch), 32'(ch));
    @(posedge clk);
    #1;
    chk({name, "/idle"}, 32'(state_out), 32'd0);
  endtask

  initial begin
    int n;
    int ng;
    int no;
    logic [N_CH-1:0] r;

    // ch, sample, expected residual (running predictor state from reset)
    vecs[0]  = '{0, 8'd100, 8'h3F};  // 100-0 -> clip 63, p0=63
    vecs[1]  = '{0, 8'd100, 8'h25};  // 100-63=37, p0=100
    vecs[2]  = '{0, 8'd0,   8'hC1};  // -100 -> -63, p0=37
    vecs[3]  = '{1, 8'd10,  8'h0A};  // p1=10
    vecs[4]  = '{0, 8'd37,  8'h00};  // p0 still 37
    vecs[5]  = '{1, 8'd200, 8'h3F};  // 190 -> 63, p1=73
    vecs[6]  = '{3, 8'd255, 8'h3F};  // p3=63
    vecs[7]  = '{3, 8'd255, 8'h3F};  // 192 -> 63, p3=126
    vecs[8]  = '{3, 8'd0,   8'hC1};  // -126 -> -63, p3=63
    vecs[9]  = '{1, 8'd73,  8'h00};
    vecs[10] = '{3, 8'd64,  8'h01};  // p3=64
    vecs[11] = '{2, 8'd0,   8'h00};

    reset = 1'b1;
    bus.req_valid = '1;
    bus.req_data  = '0;
    bus.out_ready = 1'b1;
`ifdef DPCM_PRED_CLEAR_EN
    pred_clear = '0;
`endif
    @(negedge clk);
    chk("reset/req_ready", 32'(bus.req_ready), 32'd0);
    do_reset();
    @(negedge clk);
    chk("reset/state", 32'(state_out), 32'd0);
    chk("reset/out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset/out_data", 32'(bus.out_data), 32'd0);
    chk("reset/out_ch", 32'(bus.out_ch), 32'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      do_txn(vecs[i].ch, vecs[i].data, vecs[i].exp_d, $sformatf("vec%0d", i));
    end

    // All channels requesting: grants 0,1,2,3 spaced 4 cycles apart.
    do_reset();
    bus.req_data  = {8'd8, 8'd7, 8'd6, 8'd5};
    bus.req_valid = 4'hF;
    ng = 0;
    no = 0;
    for (int cyc = 0; cyc < 40 && no < 4; cyc++) begin
      @(negedge clk);
      r = '0;
      if (bus.out_valid) begin
        outs[no] = bus.out_data;
        no++;
      end
      if (bus.req_ready != '0 && ng < 4) begin
        for (int i = 0; i < N_CH; i++) begin
          if (bus.req_ready[i]) gnt_ch[ng] = i;
        end
        gnt_cyc[ng] = cyc;
        ng++;
        r = bus.req_ready;
      end
      @(posedge clk);
      #1;
      bus.req_valid = bus.req_valid & ~r;
    end
    chk("rr/grant_count", 32'(ng), 32'd4);
    chk("rr/out_count", 32'(no), 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rr/grant%0d", k), 32'(gnt_ch[k]), 32'(k));
      chk($sformatf("rr/out%0d", k), 32'(outs[k]), 32'(5 + k));
      if (k > 0) chk($sformatf("rr/gap%0d", k), 32'(gnt_cyc[k] - gnt_cyc[k-1]), 32'd4);
    end
    // After ch3, ch0 wins over ch2; then ch2 wins over a re-requesting ch0.
    bus.req_valid = 4'b0101;
    @(negedge clk);
    chk("rr/after3", 32'(bus.req_ready), 32'b0001);
    @(posedge clk);
    #1;
    n = 0;
    @(negedge clk);
    while (bus.req_ready == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rr/rotate", 32'(bus.req_ready), 32'b0100);

    // Back-pressure: out_ready low holds the residual and blocks new grants.
    do_reset();
    bus.out_ready = 1'b0;
    bus.req_valid = 4'b0010;
    bus.req_data[15:8] = 8'd50;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready[1] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp/grant", 32'(bus.req_ready), 32'b0010);
    @(posedge clk);
    #1;
    bus.req_valid = 4'b0100;
    n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp/valid%0d", c), 32'(bus.out_valid), 32'd1);
      chk($sformatf("bp/data%0d", c), 32'(bus.out_data), 32'h32);
      chk($sformatf("bp/ch%0d", c), 32'(bus.out_ch), 32'd1);
      chk($sformatf("bp/noready%0d", c), 32'(bus.req_ready), 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    bus.req_valid = '0;
    @(posedge clk);
    #1;
    chk("bp/idle", 32'(state_out), 32'd0);
    chk("bp/valid_drop", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("bp/skip_dropped", 32'(state_out), 32'd0);

    // Reset during SAT of a ch2 transaction aborts it.
    do_reset();
    bus.req_valid = 4'b0100;
    bus.req_data[23:16] = 8'd100;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready[2] && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    @(negedge clk);
    chk("rst/diff", 32'(state_out), 32'd1);
    @(posedge clk);
    #1;
    chk("rst/sat", 32'(state_out), 32'd2);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst/state", 32'(state_out), 32'd0);
    chk("rst/out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst/out_data", 32'(bus.out_data), 32'd0);
    do_txn(2, 8'd20, 8'h14, "rst/next");

`ifdef DPCM_PRED_CLEAR_EN
    do_reset();
    do_txn(0, 8'd100, 8'h3F, "clr/seed");
    pred_clear = 4'b0001;
    @(posedge clk);
    #1;
    pred_clear = '0;
    do_txn(0, 8'd40, 8'h28, "clr/idle");
    // Clear coincides with the SAT write of a 100-40 residual.
    bus.req_valid = 4'b0001;
    bus.req_data[7:0] = 8'd100;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    pred_clear = 4'b0001;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    pred_clear = '0;
    chk("clr/sat_valid", 32'(bus.out_valid), 32'd1);
    chk("clr/sat_data", 32'(bus.out_data), 32'h3C);
    @(posedge clk);
    #1;
    do_txn(0, 8'd10, 8'h0A, "clr/after");
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
